// File: rtl/hmcs_pkg.sv
// Shared constants and helpers for the HMCS44A key-matrix companion logic.
package hmcs_pkg;

  localparam int unsigned HMCS_COLS = 16;
  localparam int unsigned HMCS_ROWS = 4;
  localparam int unsigned HMCS_KEYS = HMCS_COLS * HMCS_ROWS;

  typedef logic [5:0] key_idx_t;

  // Flat key number for a matrix position: col*4 + row.
  function automatic key_idx_t key_index(input int unsigned col, input int unsigned row);
    return key_idx_t'(col * HMCS_ROWS + row);
  endfunction

endpackage

// File: rtl/hmcs_debounce.sv
// Single-bit debouncer: a DEB_LEN-deep sample history shifted on tick; the
// output follows the input only once every history bit agrees.
module hmcs_debounce #(
  parameter int unsigned DEB_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic q
);

  logic [DEB_LEN-1:0] hist_q, hist_d;
  logic               q_q, q_d;

  // Shift a new sample in on tick and resolve the state from the fresh history,
  // so the debounced output moves on the same edge that consumes the tick.
  always_comb begin
    hist_d = hist_q;
    q_d    = q_q;
    if (tick) begin
      hist_d = {hist_q[DEB_LEN-2:0], raw};
      if (&hist_d) begin
        q_d = 1'b1;
      end else if (~|hist_d) begin
        q_d = 1'b0;
      end
    end
  end

  // History and state registers; reset beats a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      q_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      q_q    <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hmcs_key_matrix.sv
// Key-matrix front end for the HMCS44A core: debounces 64 keys, answers the
// core's column strobes with row data on ri0, and (with HMCS_KEYMTX_INT_EN
// defined) drives int0/int1 from two debounced buttons. Without the macro
// int0/int1 are tied low and the button logic is not built.
module hmcs_key_matrix
  import hmcs_pkg::*;
#(
  parameter int unsigned DEB_DIV    = 400,
  parameter int unsigned DEB_LEN    = 3,
  parameter int unsigned INT1_LEN   = 8,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_strobe,
  input  logic [63:0] keys,
  input  logic        btn0,
  input  logic        btn1,
  output logic [3:0]  ri0,
  output logic [3:0]  ri1,
  output logic [3:0]  ri2,
  output logic [3:0]  ri3,
  output logic        int0,
  output logic        int1,
  output logic [63:0] keys_db
);

  localparam int unsigned CntW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [CntW-1:0] DivMax = CntW'(DEB_DIV - 1);
  localparam logic [3:0] RiInv = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CntW-1:0] div_q, div_d;
  logic            tick;
  logic [15:0]     d_q, d_d;
  logic [3:0]      ri0_q, ri0_d;

  assign tick = (div_q == DivMax);

  // Debounce sample-rate divider.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // One debouncer per matrix key.
  for (genvar c = 0; c < HMCS_COLS; c++) begin : g_col
    for (genvar r = 0; r < HMCS_ROWS; r++) begin : g_row
      localparam key_idx_t K = key_index(c, r);
      hmcs_debounce #(
        .DEB_LEN (DEB_LEN)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (keys[K]),
        .q     (keys_db[K])
      );
    end
  end

  // Wired-OR matrix read: every selected column contributes its pressed rows.
  always_comb begin
    d_d   = d_strobe;
    ri0_d = '0;
    for (int unsigned c = 0; c < HMCS_COLS; c++) begin
      for (int unsigned r = 0; r < HMCS_ROWS; r++) begin
        if (d_q[c] && keys_db[key_index(c, r)]) begin
          ri0_d[r] = 1'b1;
        end
      end
    end
  end

  // Strobe capture and row output registers (2-cycle strobe-to-row latency).
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q   <= '0;
      ri0_q <= '0;
    end else begin
      d_q   <= d_d;
      ri0_q <= ri0_d;
    end
  end

  // Inversion sits after the register so reset yields 4'hF in pull-up mode.
  assign ri0 = ri0_q ^ RiInv;
  assign ri1 = RiInv;
  assign ri2 = RiInv;
  assign ri3 = RiInv;

`ifdef HMCS_KEYMTX_INT_EN
  localparam int unsigned Int1W = $clog2(INT1_LEN + 1);
  localparam logic [Int1W-1:0] Int1Load = Int1W'(INT1_LEN);

  logic             btn0_db, btn1_db;
  logic             btn1_prev_q, btn1_prev_d;
  logic             int0_q, int0_d;
  logic [Int1W-1:0] int1_cnt_q, int1_cnt_d;

  hmcs_debounce #(
    .DEB_LEN (DEB_LEN)
  ) u_deb_btn0 (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (btn0),
    .q     (btn0_db)
  );

  hmcs_debounce #(
    .DEB_LEN (DEB_LEN)
  ) u_deb_btn1 (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (btn1),
    .q     (btn1_db)
  );

  // int0 mirrors btn0; a btn1 rising edge (re)loads the int1 pulse counter.
  always_comb begin
    int0_d      = btn0_db;
    btn1_prev_d = btn1_db;
    int1_cnt_d  = int1_cnt_q;
    if (btn1_db && !btn1_prev_q) begin
      int1_cnt_d = Int1Load;
    end else if (int1_cnt_q != '0) begin
      int1_cnt_d = int1_cnt_q - 1'b1;
    end
  end

  // Interrupt state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      int0_q      <= 1'b0;
      btn1_prev_q <= 1'b0;
      int1_cnt_q  <= '0;
    end else begin
      int0_q      <= int0_d;
      btn1_prev_q <= btn1_prev_d;
      int1_cnt_q  <= int1_cnt_d;
    end
  end

  assign int0 = int0_q;
  assign int1 = (int1_cnt_q != '0);
`else
  logic unused_btn;
  assign unused_btn = btn0 ^ btn1;
  assign int0 = 1'b0;
  assign int1 = 1'b0;
`endif

endmodule

// File: tb/tb_hmcs_key_matrix.sv
// Directed bench for hmcs_key_matrix: a fast-tick instance (DEB_DIV=4) for the
// matrix path, and an ACTIVE_LOW instance with a tick every cycle for the
// pull-up outputs and int1 pulse extension.
module tb_hmcs_key_matrix;

  localparam int unsigned DEB_LEN   = 3;
  localparam int unsigned DEB_DIV   = 4;
  localparam int unsigned INT1_LEN  = 8;
  localparam int unsigned F_DEB_LEN = 2;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst, rst_f;
  logic [15:0] ds, ds_f;
  logic [63:0] keys, keys_f;
  logic        b0, b1, b0_f, b1_f;
  logic [3:0]  ri0, ri1, ri2, ri3, ri0_f, ri1_f, ri2_f, ri3_f;
  logic        int0, int1, int0_f, int1_f;
  logic [63:0] keys_db, keys_db_f;

  always #5 clk = ~clk;

  hmcs_key_matrix #(
    .DEB_DIV    (DEB_DIV),
    .DEB_LEN    (DEB_LEN),
    .INT1_LEN   (INT1_LEN),
    .ACTIVE_LOW (0)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .d_strobe (ds),
    .keys     (keys),
    .btn0     (b0),
    .btn1     (b1),
    .ri0      (ri0),
    .ri1      (ri1),
    .ri2      (ri2),
    .ri3      (ri3),
    .int0     (int0),
    .int1     (int1),
    .keys_db  (keys_db)
  );

  hmcs_key_matrix #(
    .DEB_DIV    (1),
    .DEB_LEN    (F_DEB_LEN),
    .INT1_LEN   (INT1_LEN),
    .ACTIVE_LOW (1)
  ) dut_f (
    .clk      (clk),
    .reset    (rst_f),
    .d_strobe (ds_f),
    .keys     (keys_f),
    .btn0     (b0_f),
    .btn1     (b1_f),
    .ri0      (ri0_f),
    .ri1      (ri1_f),
    .ri2      (ri2_f),
    .ri3      (ri3_f),
    .int0     (int0_f),
    .int1     (int1_f),
    .keys_db  (keys_db_f)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    logic bad;
    logic hi;
    int   cnt;

    // Reset with everything pressed and every column strobed.
    rst = 1'b1; ds = 16'hFFFF; keys = '1; b0 = 1'b0; b1 = 1'b0;
    rst_f = 1'b1; ds_f = 16'h0000; keys_f = '0; b0_f = 1'b0; b1_f = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (ri0 !== 4'h0 || keys_db !== '0 || int0 !== 1'b0 || int1 !== 1'b0) bad = 1'b1;
    end
    expect_val("reset_outputs_zero", 64'd0);
    chk({63'd0, bad});
    expect_val("reset_ri_active_low", 64'hFFFF);
    chk({48'd0, ri0_f, ri1_f, ri2_f, ri3_f});

    // Release: keys_db stays 0 until the DEB_LEN-th tick (ticks land on edges 4, 8, 12).
    rst = 1'b0; rst_f = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cyc(1);
      if (ri0 !== 4'h0 || keys_db !== '0) bad = 1'b1;
    end
    expect_val("post_reset_hold_zero", 64'd0);
    chk({63'd0, bad});
    cyc(3);
    expect_val("all_keys_db", {64{1'b1}});
    chk(keys_db);
    expect_val("all_cols_ri0", 64'hF);
    chk({60'd0, ri0});

    // Clean restart for the matrix tests.
    rst = 1'b1; keys = '0; ds = 16'h0000;
    cyc(2);
    rst = 1'b0;

    // Column read: key 5 is col 1 row 1.
    keys[5] = 1'b1;
    cyc((DEB_LEN + 2) * DEB_DIV);
    expect_val("key5_db", 64'h20);
    chk(keys_db);
    ds = 16'h0002;
    cyc(1);
    expect_val("col1_ri0_after_1", 64'h0);
    chk({60'd0, ri0});
    cyc(1);
    expect_val("col1_ri0_after_2", 64'h2);
    chk({60'd0, ri0});
    ds = 16'h0001;
    cyc(2);
    expect_val("col0_ri0", 64'h0);
    chk({60'd0, ri0});

    // Wired-OR of key 0 (col 0 row 0) and key 7 (col 1 row 3).
    keys = 64'h81;
    cyc((DEB_LEN + 2) * DEB_DIV);
    ds = 16'h0003;
    cyc(2);
    expect_val("wired_or_ri0", 64'h9);
    chk({60'd0, ri0});
    ds = 16'h0002;
    cyc(2);
    expect_val("col1_only_ri0", 64'h8);
    chk({60'd0, ri0});
    ds = 16'h0000;
    cyc(2);
    expect_val("no_col_ri0", 64'h0);
    chk({60'd0, ri0});
    expect_val("ri1_3_reserved", 64'h0);
    chk({52'd0, ri1, ri2, ri3});

    // Bounce rejection on key 0.
    keys = '0;
    cyc((DEB_LEN + 2) * DEB_DIV);
    expect_val("bounce_start_db", 64'h0);
    chk(keys_db);
    hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys[0] = ~keys[0];
      for (int j = 0; j < int'(DEB_DIV); j++) begin
        cyc(1);
        if (keys_db[0] !== 1'b0) hi = 1'b1;
      end
    end
    expect_val("bounce_no_change", 64'h0);
    chk({63'd0, hi});
    keys[0] = 1'b1;
    cyc(DEB_DIV);
    expect_val("hold_one_tick", 64'h0);
    chk({63'd0, keys_db[0]});
    cyc(DEB_LEN * DEB_DIV);
    expect_val("hold_settled", 64'h1);
    chk({63'd0, keys_db[0]});

    // ACTIVE_LOW instance: idle rows read 4'hF, pressed row reads low.
    expect_val("al_idle_ri", 64'hFFFF);
    chk({48'd0, ri0_f, ri1_f, ri2_f, ri3_f});
    keys_f[5] = 1'b1;
    ds_f = 16'h0002;
    cyc(F_DEB_LEN + 4);
    expect_val("al_key5_ri0", 64'hD);
    chk({60'd0, ri0_f});
    expect_val("al_ri1_3", 64'hFFF);
    chk({52'd0, ri1_f, ri2_f, ri3_f});
    keys_f = '0;
    ds_f = 16'h0000;
    cyc(F_DEB_LEN + 4);

`ifdef HMCS_KEYMTX_INT_EN
    // int0 follows the debounced button.
    b0 = 1'b1;
    cyc((DEB_LEN + 2) * DEB_DIV);
    expect_val("int0_high", 64'h1);
    chk({63'd0, int0});
    b0 = 1'b0;
    cyc((DEB_LEN + 2) * DEB_DIV);
    expect_val("int0_low", 64'h0);
    chk({63'd0, int0});

    // Single int1 pulse width.
    cnt = 0;
    b1 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (int1 === 1'b1) cnt++;
    end
    expect_val("int1_width", 64'(INT1_LEN));
    chk(64'(cnt));

    // Second debounced edge 2*F_DEB_LEN cycles into the pulse reloads the counter.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) b1_f = 1'b1;
      if (i == int'(F_DEB_LEN)) b1_f = 1'b0;
      if (i == int'(2 * F_DEB_LEN)) b1_f = 1'b1;
      cyc(1);
      if (int1_f === 1'b1) cnt++;
    end
    expect_val("int1_extended", 64'(2 * F_DEB_LEN + INT1_LEN));
    chk(64'(cnt));

    // Reset mid-pulse kills int1 with nothing left over.
    b1_f = 1'b0;
    cyc(6);
    b1_f = 1'b1;
    cyc(F_DEB_LEN + 3);
    expect_val("int1_mid_pulse", 64'h1);
    chk({63'd0, int1_f});
    rst_f = 1'b1; b1_f = 1'b0;
    cyc(1);
    expect_val("int1_reset_drop", 64'h0);
    chk({63'd0, int1_f});
    rst_f = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (int1_f !== 1'b0) bad = 1'b1;
    end
    expect_val("int1_no_residual", 64'h0);
    chk({63'd0, bad});
`else
    // Without the interrupt option the buttons must have no effect.
    b0 = 1'b1; b1 = 1'b1; b0_f = 1'b1; b1_f = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (int0 !== 1'b0 || int1 !== 1'b0 || int0_f !== 1'b0 || int1_f !== 1'b0) bad = 1'b1;
    end
    expect_val("int_tied_low", 64'h0);
    chk({63'd0, bad});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hmcs_key_matrix.md
# hmcs_key_matrix

Input-side companion to the HMCS44A core: it reads the MCU's D-port column strobes and answers on the R input ports with debounced key-matrix row data, as a real keyboard matrix would. It also generates the int0 and int1 lines from two dedicated buttons. It sits between the host or board key inputs and the core's `Ri0..Ri3`, `int0` and `int1` pins, and runs on the same 400 kHz `clk` as the core.

## Interface
Parameters:
- `DEB_DIV`, default 400: number of `clk` cycles between debounce samples (1 ms).
- `DEB_LEN`, default 3: number of consecutive equal samples needed to change a debounced state (range 2–8).
- `INT1_LEN`, default 8: width of the int1 pulse, in `clk` cycles.
- `ACTIVE_LOW`, default 0: when 1, `ri0..ri3` are inverted (pull-up matrix).

Ports (clk, reset synchronous, active-high; clock clk):
- `clk` in 1: 400 kHz system clock, shared with the core.
- `reset` in 1: synchronous, active-high.
- `d_strobe` in 16: the core's `Do`; bit n high means column n is selected.
- `keys` in 64: raw key inputs, 1 = pressed; key index = col*4 + row.
- `btn0` in 1: raw interrupt-0 button.
- `btn1` in 1: raw counter/interrupt-1 button.
- `ri0`, `ri1`, `ri2`, `ri3` out 4 each: row data to the core's `Ri0..Ri3`.
- `int0` out 1: to the core's `int0`.
- `int1` out 1: to the core's `int1`.
- `keys_db` out 64: debounced key state, for debug and overlay.

## Operation
- Tick generator:
  - Counter 0..DEB_DIV-1; `tick` is asserted for one cycle when the count wraps.
  - Reset sets the count to 0.
- Debounce, per key and per button:
  - Sample history shift register, DEB_LEN bits, shifted on `tick` only.
  - When all history bits are 1, the debounced state becomes 1. When all are 0, it becomes 0. Otherwise the state holds.
  - Reset clears all history bits and all debounced states.
- Column read:
  - `d_q` is `d_strobe` registered every cycle.
  - Row r of `ri0` = OR over all columns c with `d_q[c]` set of `keys_db[c*4+r]`.
  - `ri0` carries rows 0..3.
  - `ri1`, `ri2` and `ri3` are reserved: constant 0 before any ACTIVE_LOW inversion.
  - Multiple active columns OR together (wired-OR matrix).
  - No column active gives `ri0` = 0.
- int0: equals the debounced `btn0`, registered.
- int1:
  - A rising edge of debounced `btn1` loads a counter with INT1_LEN.
  - `int1` is high while the counter is nonzero; the counter decrements every cycle.
  - A new edge during a pulse reloads the counter (the pulse is extended, not doubled).
- ACTIVE_LOW inverts `ri0..ri3` only; the int lines are never inverted.

## Timing
- `d_strobe` to `ri0`: 2 cycles (`d_q` register, then output register). This is well under one MCU cycle of 4 `clk`.
- Key edge to debounced state: between DEB_LEN and DEB_LEN+1 ticks.
- Debounced state to `ri0`: 1 cycle. To `int0`: 1 cycle. To the start of `int1`: 1 cycle.
- `keys_db` changes only in the cycle after `tick`.
- Reset values:
  - `ri0..ri3` = 0, or 4'hF each when ACTIVE_LOW.
  - `int0` = 0, `int1` = 0, `keys_db` = 0.
  - The int1 counter and the tick counter are 0.
- Reset mid-pulse: `int1` drops on the next edge; no residual pulse after reset is released.
- Simultaneous `tick` and `reset`: reset wins.

## Configuration
- Macro `HMCS_KEYMTX_INT_EN`.
- Defined: the `btn0`/`btn1` debouncers and the int0/int1 logic are built as above.
- Undefined:
  - `int0` and `int1` are tied to 0.
  - `btn0` and `btn1` are ignored.
  - The debouncers for them and the int1 counter are not instantiated.
  - The matrix path is unchanged.

## Structure
- Shared package `hmcs_pkg` holds:
  - `HMCS_COLS` = 16 and `HMCS_ROWS` = 4.
  - Typedef `key_idx_t` (6 bits).
  - Function `key_index(col, row)`.
- Sub-module `hmcs_debounce`:
  - One bit, parameter DEB_LEN.
  - Inputs `clk`, `reset`, `tick`, `raw`; output `q`.
  - Instantiated 64 times in a generate loop, plus 2 more under the macro.

## Test plan
- Reset check: assert reset with `keys` = all 1 and `d_strobe` = 16'hFFFF. Required: `ri0` = 0, `keys_db` = 0, `int0` = 0 and `int1` = 0 for the whole reset, and for DEB_LEN ticks after release.
- Column read: set key 5 (col 1, row 1), wait DEB_LEN+1 ticks, drive `d_strobe` = 16'h0002. Required: `ri0` = 4'b0010 exactly 2 cycles later. With `d_strobe` = 16'h0001, `ri0` = 0.
- Wired-OR: set keys 0 and 7 debounced, drive `d_strobe` = 16'h0003. Required: `ri0` = 4'b1001.
- Bounce rejection: toggle key 0 at each tick for 10 ticks. Required: `keys_db[0]` stays 0. Then hold it high; `keys_db[0]` = 1 after DEB_LEN ticks.
- int1 pulse: press `btn1`. Required: `int1` high for exactly 8 cycles (INT1_LEN = 8). A second debounced edge 3 cycles into the pulse extends it to 3 + 8 cycles total.
- ACTIVE_LOW = 1, no keys pressed. Required: `ri0` = 4'hF and `ri1..ri3` = 4'hF.
